// File: rtl/calc2_req_adapter.sv
// Transaction-to-calc2 request adapter: tag allocation, two-cycle request drive and a credit-protected response FIFO.
// Optional per-tag response timeout is compiled in with CALC2_ADAPTER_TIMEOUT_EN.
module calc2_req_adapter #(
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_cmd,
    input  logic [31:0] in_op1,
    input  logic [31:0] in_op2,
    output logic [1:0]  in_tag,
    output logic [3:0]  req_cmd_out,
    output logic [31:0] req_data_out,
    output logic [1:0]  req_tag_out,
    input  logic [1:0]  resp_in,
    input  logic [31:0] resp_data_in,
    input  logic [1:0]  resp_tag_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_status,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_tag,
    output logic [3:0]  busy_tags,
    output logic        err_spurious
);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_OP2  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       req_cmd_q, req_cmd_d;
    logic [31:0]      req_data_q, req_data_d;
    logic [1:0]       req_tag_q, req_tag_d;
    logic [31:0]      op2_q, op2_d;
    logic [3:0]       busy_q, busy_d;
    logic [3:0]       local_cnt_q, local_cnt_d;
    logic [3:0]       fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             err_spurious_q, err_spurious_d;
    logic [35:0]      mem [RSP_DEPTH];

    logic [1:0]  alloc_tag;
    logic [2:0]  busy_cnt;
    logic [4:0]  credits;
    logic        accept, pop, push, local_dec;
    logic [35:0] wr_entry, head;
    logic [3:0]  expired;
    logic [1:0]  to_sel;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        alloc_tag = 2'd0;
        busy_cnt  = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!busy_q[i]) alloc_tag = 2'(i);
        end
        for (int i = 0; i < 4; i++) begin
            busy_cnt = busy_cnt + {2'b0, busy_q[i]};
        end
    end

    // Credits cover tags in flight, queued responses and not-yet-pushed cmd-0 entries.
    assign credits   = {2'b0, busy_cnt} + {1'b0, fifo_cnt_q} + {1'b0, local_cnt_q};
    assign in_ready  = reset && (state_q == S_IDLE) && !(&busy_q) && (credits < 5'(RSP_DEPTH));
    assign in_tag    = in_ready ? alloc_tag : 2'd0;
    assign accept    = in_valid && in_ready;
    assign rsp_valid = (fifo_cnt_q != 4'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign head      = mem[rd_ptr_q];

    assign rsp_status   = rsp_valid ? head[35:34] : 2'd0;
    assign rsp_data     = rsp_valid ? head[33:2]  : 32'd0;
    assign rsp_tag      = rsp_valid ? head[1:0]   : 2'd0;
    assign req_cmd_out  = req_cmd_q;
    assign req_data_out = req_data_q;
    assign req_tag_out  = req_tag_q;
    assign busy_tags    = busy_q;
    assign err_spurious = err_spurious_q;

`ifdef CALC2_ADAPTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_to
            logic [CNT_W-1:0] cnt_q, cnt_d;
            always_comb begin
                cnt_d = cnt_q;
                if ((accept && in_cmd != 4'd0 && alloc_tag == 2'(gi)) ||
                    (state_q == S_CMD && req_tag_q == 2'(gi))) begin
                    cnt_d = '0;
                end else if (busy_q[gi] && cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            always_ff @(posedge c_clk or negedge reset) begin
                if (!reset) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end
            assign expired[gi] = busy_q[gi] && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
        end
    endgenerate
`else
    assign expired = 4'd0;
`endif

    always_comb begin
        to_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (expired[i]) to_sel = 2'(i);
        end
    end

    // Single FIFO write port: calc2 response beats local cmd-0 entry beats timeout.
    always_comb begin
        push      = 1'b0;
        wr_entry  = 36'd0;
        local_dec = 1'b0;
        busy_d    = busy_q;
        if (resp_in != 2'd0 && busy_q[resp_tag_in]) begin
            push              = 1'b1;
            wr_entry          = {resp_in, resp_data_in, resp_tag_in};
            busy_d[resp_tag_in] = 1'b0;
        end else if (local_cnt_q != 4'd0) begin
            push      = 1'b1;
            wr_entry  = {2'd2, 32'd0, 2'd0};
            local_dec = 1'b1;
        end else if (|expired) begin
            push           = 1'b1;
            wr_entry       = {2'd3, 32'd0, to_sel};
            busy_d[to_sel] = 1'b0;
        end
        if (accept && in_cmd != 4'd0) busy_d[alloc_tag] = 1'b1;
        err_spurious_d = (resp_in != 2'd0) && !busy_q[resp_tag_in];
        local_cnt_d    = local_cnt_q + {3'b0, accept && in_cmd == 4'd0} - {3'b0, local_dec};
        fifo_cnt_d     = fifo_cnt_q + {3'b0, push} - {3'b0, pop};
        wr_ptr_d       = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d       = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    end

    always_comb begin
        state_d    = state_q;
        op2_d      = op2_q;
        req_cmd_d  = 4'd0;
        req_data_d = 32'd0;
        req_tag_d  = 2'd0;
        case (state_q)
            S_IDLE: begin
                if (accept && in_cmd != 4'd0) begin
                    req_cmd_d  = in_cmd;
                    req_data_d = in_op1;
                    req_tag_d  = alloc_tag;
                    op2_d      = in_op2;
                    state_d    = S_CMD;
                end
            end
            S_CMD: begin
                req_data_d = op2_q;
                req_tag_d  = req_tag_q;
                state_d    = S_OP2;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            req_cmd_q      <= 4'd0;
            req_data_q     <= 32'd0;
            req_tag_q      <= 2'd0;
            op2_q          <= 32'd0;
            busy_q         <= 4'd0;
            local_cnt_q    <= 4'd0;
            fifo_cnt_q     <= 4'd0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_cmd_q      <= req_cmd_d;
            req_data_q     <= req_data_d;
            req_tag_q      <= req_tag_d;
            op2_q          <= op2_d;
            busy_q         <= busy_d;
            local_cnt_q    <= local_cnt_d;
            fifo_cnt_q     <= fifo_cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    always_ff @(posedge c_clk) begin
        if (push) mem[wr_ptr_q] <= wr_entry;
    end
endmodule

// File: tb/tb_calc2_req_adapter.sv
// Scoreboard bench for calc2_req_adapter (default build): bench acts as source, calc2 and sink.
module tb_calc2_req_adapter;
    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [3:0]  in_cmd = '0;
    logic [31:0] in_op1 = '0, in_op2 = '0;
    logic [1:0]  in_tag;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  req_tag_out;
    logic [1:0]  resp_in = '0;
    logic [31:0] resp_data_in = '0;
    logic [1:0]  resp_tag_in = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_tag;
    logic [3:0]  busy_tags;
    logic        err_spurious;

    calc2_req_adapter dut (
        .c_clk(c_clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
        .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
        .req_cmd_out(req_cmd_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
        .resp_in(resp_in), .resp_data_in(resp_data_in), .resp_tag_in(resp_tag_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .busy_tags(busy_tags), .err_spurious(err_spurious)
    );

    always #5 c_clk = ~c_clk;

    logic [35:0] exp_q [$];
    bit          m_busy [4];
    logic [3:0]  m_cmd [4];
    logic [31:0] m_op1 [4];
    logic [31:0] m_op2 [4];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    function automatic int m_busy_cnt();
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic bit m_ready();
        return (m_busy_cnt() < 4) && (m_busy_cnt() + exp_q.size() < 4);
    endfunction

    function automatic logic [1:0] m_low_free();
        for (int i = 0; i < 4; i++) if (!m_busy[i]) return 2'(i);
        return 2'd0;
    endfunction

    function automatic logic [3:0] m_busy_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit is_legal(input logic [3:0] c);
        return c == 4'd1 || c == 4'd2 || c == 4'd5 || c == 4'd6;
    endfunction

    function automatic logic [31:0] calc_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd1: return a + b;
            4'd2: return a - b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic cyc();
        @(posedge c_clk);
        #1;
    endtask

    // Issue one operation (caller guarantees the model predicts in_ready) and check the request pins.
    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [1:0] t;
        t = m_low_free();
        in_valid = 1'b1; in_cmd = c; in_op1 = a; in_op2 = b;
        #1;
        chk("in_ready_idle", in_ready, m_ready());
        if (c != 4'd0) chk("in_tag", in_tag, t);
        cyc();
        in_valid = 1'b0;
        if (c != 4'd0) begin
            m_busy[t] = 1'b1; m_cmd[t] = c; m_op1[t] = a; m_op2[t] = b;
            chk("req_cmd_phase", {req_cmd_out, req_data_out, req_tag_out}, {c, a, t});
            chk("in_ready_busy", in_ready, 0);
        end else begin
            exp_q.push_back({2'd2, 32'd0, 2'd0});
            chk("req_cmd0_idle", {req_cmd_out, req_data_out, req_tag_out}, 0);
        end
        cyc();
        chk("req_op2_phase", {req_cmd_out, req_data_out, req_tag_out}, (c != 4'd0) ? {4'd0, b, t} : 38'd0);
        cyc();
        chk("req_idle", {req_cmd_out, req_data_out, req_tag_out}, 0);
        $display("op cmd=%0d op1=%h op2=%h tag=%0d", c, a, b, t);
    endtask

    task automatic respond(input logic [1:0] t);
        logic [1:0]  st;
        logic [31:0] d;
        st = is_legal(m_cmd[t]) ? 2'd1 : 2'd2;
        d  = is_legal(m_cmd[t]) ? calc_ref(m_cmd[t], m_op1[t], m_op2[t]) : $urandom;
        resp_in = st; resp_data_in = d; resp_tag_in = t;
        exp_q.push_back({st, d, t});
        m_busy[t] = 1'b0;
        cyc();
        resp_in = 2'd0;
        chk("no_spurious", err_spurious, 0);
        chk("busy_tags", busy_tags, m_busy_vec());
        $display("resp tag=%0d status=%0d data=%h", t, st, d);
    endtask

    task automatic spurious(input logic [1:0] t);
        resp_in = 2'd1; resp_data_in = $urandom; resp_tag_in = t;
        cyc();
        resp_in = 2'd0;
        chk("spurious_pulse", err_spurious, 1);
        cyc();
        chk("spurious_end", err_spurious, 0);
        $display("spurious tag=%0d", t);
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) cyc();
        chk("drain_bound", exp_q.size(), 0);
        cyc();
        chk("fifo_empty", rsp_valid, 0);
    endtask

    always @(negedge c_clk) begin
        if (reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {rsp_status, rsp_data, rsp_tag}, 0);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                chk("rsp", {rsp_status, rsp_data, rsp_tag}, e);
                $display("pop status=%0d data=%h tag=%0d", rsp_status, rsp_data, rsp_tag);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cmd_tab [11];
        cmd_tab = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd15, 4'd1, 4'd2, 4'd5, 4'd6};
        for (int i = 0; i < 4; i++) m_busy[i] = 1'b0;

        #2;
        chk("reset_outputs", {in_ready, in_tag, req_cmd_out, req_data_out, req_tag_out,
                              rsp_valid, rsp_status, rsp_data, rsp_tag, busy_tags, err_spurious}, 0);
        repeat (2) @(posedge c_clk);
        #1 reset = 1'b1;
        rsp_ready = 1'b1;
        cyc();

        // Add 0x30 + 0x20 on tag 0
        do_op(4'd1, 32'h30, 32'h20);
        respond(2'd0);
        drain();

        // Four outstanding ops, then out-of-order responses
        for (int i = 0; i < 4; i++) do_op(4'd1 + 4'(i % 2), $urandom, $urandom);
        chk("full_in_ready", in_ready, 0);
        respond(2'd2);
        respond(2'd0);
        drain();
        do_op(4'd5, 32'h1, 32'h4);
        respond(2'd1); respond(2'd3); respond(2'd0);
        drain();

        // FIFO full with no busy tags blocks acceptance
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_op(4'd6, $urandom, $urandom);
        respond(2'd3); respond(2'd1); respond(2'd0); respond(2'd2);
        chk("credit_block", in_ready, 0);
        chk("fifo_held", rsp_valid, 1);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        chk("credit_return", in_ready, 1);
        drain();

        // cmd 0 local error entry and illegal command pass-through
        do_op(4'd0, $urandom, $urandom);
        do_op(4'd9, $urandom, $urandom);
        respond(2'd0);
        drain();

        // Spurious response
        spurious(2'd3);
        chk("spurious_no_rsp", rsp_valid, 0);

        // Reset during OP2
        in_valid = 1'b1; in_cmd = 4'd2; in_op1 = 32'h1234; in_op2 = 32'h77;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("op2_before_reset", req_data_out, 32'h77);
        reset = 1'b0;
        #1;
        chk("reset_req", {req_cmd_out, req_data_out, req_tag_out}, 0);
        chk("reset_busy", busy_tags, 0);
        chk("reset_ready", in_ready, 0);
        exp_q.delete();
        for (int i = 0; i < 4; i++) m_busy[i] = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        #1;
        chk("post_reset_ready", in_ready, 1);
        do_op(4'd1, 32'h5, 32'h6);
        respond(2'd0);
        drain();

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            int r;
            rsp_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 5 && m_ready()) begin
                do_op(cmd_tab[$urandom_range(0, 10)], $urandom, $urandom);
            end else if (r < 9 && m_busy_cnt() > 0) begin
                int s;
                s = $urandom_range(0, 3);
                for (int k = 0; k < 4; k++) begin
                    if (m_busy[(s + k) % 4]) begin
                        respond(2'((s + k) % 4));
                        break;
                    end
                end
            end else if (r == 9 && m_busy_cnt() < 4) begin
                spurious(m_low_free());
            end else begin
                cyc();
            end
        end
        for (int k = 0; k < 4; k++) if (m_busy[k]) respond(2'(k));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/calc2_req_adapter.md
Name: calc2_req_adapter

Overview:
- Upstream request adapter for one calc2 port; one instance per port (4 total), between a transaction-level source and calc2_top reqN_*/out_*N pins.
- Accepts whole operations (cmd + two operands) over valid/ready and drives the calc2 two-cycle request protocol.
- Allocates 2-bit tags and tracks outstanding tags.
- Captures calc2 responses into a response FIFO with credit-based flow control, so no response is ever dropped.

Parameters:
- RSP_DEPTH, 4, response FIFO entries; also the credit limit (busy tags + FIFO occupancy). Legal range 1..8.
- TIMEOUT_CYCLES, 64, cycles from command phase to timeout; used only with CALC2_ADAPTER_TIMEOUT_EN.

Ports:
- c_clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- in_cmd  in  4  calc2 command (1 add, 2 sub, 5 shl, 6 shr)
- in_op1  in  32  operand 1
- in_op2  in  32  operand 2
- in_tag  out  2  tag assigned to the operation; valid in the cycle in_ready is high
- req_cmd_out  out  4  to calc2 reqN_cmd_in
- req_data_out  out  32  to calc2 reqN_data_in
- req_tag_out  out  2  to calc2 reqN_tag_in
- resp_in  in  2  from calc2 out_respN
- resp_data_in  in  32  from calc2 out_dataN
- resp_tag_in  in  2  from calc2 out_tagN
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  pop on rsp_valid && rsp_ready
- rsp_status  out  2  1 ok, 2 DUT error / illegal cmd, 3 timeout
- rsp_data  out  32  result
- rsp_tag  out  2  tag
- busy_tags  out  4  outstanding-tag bitmap
- err_spurious  out  1  one-cycle pulse: response for a non-busy tag

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FSM IDLE, busy_tags 0, FIFO empty, counters 0. Any in-flight operation is dropped silently.
- FSM IDLE -> CMD -> OP2 -> IDLE. All req_* outputs are registered.
  - IDLE: in_ready = free tag exists && (busy count + FIFO count) < RSP_DEPTH.
  - On accept: latch op2; allocate the lowest free tag (in_tag shows it combinationally); set busy bit; go to CMD.
  - CMD cycle: req_cmd_out=in_cmd, req_data_out=op1, req_tag_out=tag.
  - OP2 cycle: req_cmd_out=0, req_data_out=op2, req_tag_out=tag.
  - Back in IDLE: req_* = 0.
- in_ready is 0 in CMD and OP2. Maximum throughput is 1 operation per 3 cycles.
- in_cmd not in {1,2,5,6}: forwarded unchanged; calc2 returns status 2.
- in_cmd == 0: accepted, no tag allocated, nothing driven to calc2. A local entry {2, 0, tag 0} is pushed next cycle; it consumes one credit.
- Response capture, any cycle with resp_in != 0:
  - Tag busy: push {resp_in, resp_data_in, resp_tag_in}; clear busy bit.
  - Tag not busy: drop; err_spurious=1 for one cycle.
- Tag allocation uses the pre-edge busy vector. A tag freed in cycle N is allocatable from cycle N+1.
- FIFO: single write port; push and pop in the same cycle are allowed. Credit rule makes overflow impossible. Popping empty is ignored.
- Write-port priority (high to low): calc2 response, then local cmd-0 entry, then lowest-numbered expired timeout. Losers retry next cycle; their state is held.
- Outstanding operations complete in calc2 response order, not issue order.

Optional Feature:
- Macro CALC2_ADAPTER_TIMEOUT_EN.
- Defined:
  - Per-tag counter cleared in the CMD cycle, incremented while busy.
  - At TIMEOUT_CYCLES: push {3, 0, tag} and free the tag; counter saturates if the push loses arbitration.
  - A later response for that tag is spurious.
- Undefined: no counters; tags stay busy until a response arrives; status 3 is never produced.

Test Plan:
- Add: cmd 1, op1 0x30, op2 0x20 accepted.
  - -> req_*: (1, 0x30, 0), then (0, 0x20, 0), then zeros.
  - -> calc2 resp 1 / 0x50 / tag 0 gives rsp_valid, status 1, data 0x50, tag 0; busy_tags returns to 0.
- Four ops, no responses.
  - -> tags 0,1,2,3; in_ready stays 0 after the fourth.
  - -> responses for tag 2 then tag 0 pop in order 2, 0; tag 0 is re-allocated on the next accept.
- rsp_ready=0, four ops all answered.
  - -> FIFO holds 4; in_ready=0 although busy_tags=0.
  - -> one pop raises in_ready the next cycle.
- resp_in=1, tag 3 while busy_tags=0.
  - -> err_spurious pulses one cycle; rsp_valid stays 0.
- Macro on, TIMEOUT_CYCLES=16, cmd 5 issued, no response.
  - -> status 3, data 0, tag 0 at 16 cycles after CMD.
  - -> a later response on tag 0 pulses err_spurious.
- reset driven 0 during OP2 cycle.
  - -> req_* and busy_tags are 0 before the next clock edge.
  - -> after release, in_ready=1 and the next op gets tag 0.
